led_status_driver: RTL and testbench

Upstream producer for the LED register stage. It converts calculator and PS/2 events into the `led_input`/`leds_sel` write pair that the LED stage consumes. Event handling covers digit display, key-activity pulse stretching, a sticky overflow flag, an error blink sequence and a heartbeat. It writes only the bits that changed, so the downstream per-bit buffer keeps its value between writes.

---
 rtl/led_status_pkg.sv | 15 +
 rtl/led_pulse_stretch.sv | 41 ++++
 rtl/led_status_driver.sv | 144 ++++++++++++++
 tb/tb_led_status_driver.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/led_status_pkg.sv
// Shared constants for the LED status driver: bit map of the LED byte and
// the error-blink FSM encoding.
package led_status_pkg;
  localparam int LED_DIGIT_LSB = 0;
  localparam int LED_KEY       = 4;
  localparam int LED_OVF       = 5;
  localparam int LED_ERR       = 6;
  localparam int LED_HB        = 7;

  typedef enum logic [1:0] {
    BLK_IDLE = 2'd0,
    BLK_ON   = 2'd1,
    BLK_OFF  = 2'd2
  } blink_state_e;
endpackage

// File: rtl/led_pulse_stretch.sv
// Retriggerable one-bit stretcher: out_o stays high for LEN cycles after the
// most recent trigger.
module led_pulse_stretch #(
  parameter int          CNT_W = 27,
  parameter int unsigned LEN   = 5000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  output logic out_o
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q, act_d;

  always_comb begin
    cnt_d = cnt_q;
    act_d = act_q;
    if (trig_i) begin
      act_d = 1'b1;
      cnt_d = RELOAD;
    end else if (act_q) begin
      if (cnt_q == '0) act_d = 1'b0;
      else             cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign out_o = act_q;
endmodule

// File: rtl/led_status_driver.sv
// Turns key/overflow/error events into delta writes (led_input/leds_sel) for
// the downstream per-bit LED buffer, plus a free-running heartbeat.
module led_status_driver
  import led_status_pkg::*;
#(
  parameter int          CNT_W       = 27,
  parameter int unsigned PULSE_CYC   = 5000000,
  parameter int unsigned BLINK_HALF  = 25000000,
  parameter int unsigned BLINK_COUNT = 3,
  parameter int unsigned HB_HALF     = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_nibble,
  input  logic       ovf_set,
  input  logic       ovf_clr,
  input  logic       err_start,
  output logic [7:0] led_input,
  output logic [7:0] leds_sel,
  output logic       busy
);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] BH_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HB_HALF - 1);
  localparam logic [3:0]       BC      = 4'(BLINK_COUNT);

  logic [3:0]       digit_q, digit_d;
  logic             ovf_q, ovf_d;
  logic             hb_q, hb_d;
  logic [CNT_W-1:0] hb_cnt_q, hb_cnt_d;
  logic             key_act;

  blink_state_e     state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [3:0]       bcnt_q, bcnt_d;

  logic [7:0]       want;
  logic [7:0]       shadow_q, led_q, sel_q;
  logic             init_q;

  led_pulse_stretch #(.CNT_W(CNT_W), .LEN(PULSE_CYC)) u_key_pulse (
    .clk_i  (clk),
    .rst_ni (reset),
    .trig_i (key_valid),
    .out_o  (key_act)
  );

  always_comb begin
    digit_d  = key_valid ? key_nibble : digit_q;
    ovf_d    = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    hb_d     = hb_q;
    hb_cnt_d = hb_cnt_q + ONE;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  // err_start from any state (re)starts a full sequence.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    if (err_start) begin
      state_d = BLK_ON;
      phase_d = '0;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        BLK_ON: begin
          if (phase_q == BH_LAST) begin
            state_d = BLK_OFF;
            phase_d = '0;
          end else begin
            phase_d = phase_q + ONE;
          end
        end
        BLK_OFF: begin
          if (phase_q == BH_LAST) begin
            phase_d = '0;
            bcnt_d  = bcnt_q + 4'd1;
            state_d = ((bcnt_q + 4'd1) == BC) ? BLK_IDLE : BLK_ON;
          end else begin
            phase_d = phase_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_q  <= '0;
      ovf_q    <= 1'b0;
      hb_q     <= 1'b0;
      hb_cnt_q <= '0;
      state_q  <= BLK_IDLE;
      phase_q  <= '0;
      bcnt_q   <= '0;
    end else begin
      digit_q  <= digit_d;
      ovf_q    <= ovf_d;
      hb_q     <= hb_d;
      hb_cnt_q <= hb_cnt_d;
      state_q  <= state_d;
      phase_q  <= phase_d;
      bcnt_q   <= bcnt_d;
    end
  end

  always_comb begin
    want                         = '0;
    want[LED_DIGIT_LSB +: 4]     = digit_q;
    want[LED_KEY]                = key_act;
    want[LED_OVF]                = ovf_q;
    want[LED_ERR]                = (state_q == BLK_ON);
    want[LED_HB]                 = hb_q;
  end

  // First cycle after reset writes every bit so the unreset buffer starts at 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      init_q   <= 1'b1;
      led_q    <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
    end else if (init_q) begin
      init_q   <= 1'b0;
      led_q    <= 8'h00;
      sel_q    <= 8'hFF;
      shadow_q <= 8'h00;
    end else begin
      led_q    <= want;
      sel_q    <= want ^ shadow_q;
      shadow_q <= want;
    end
  end

  assign led_input = led_q;
  assign leds_sel  = sel_q;
  assign busy      = (state_q != BLK_IDLE);
endmodule

// File: tb/tb_led_status_driver.sv
// Bench for led_status_driver: directed scenarios with literal expectations,
// then random event traffic checked every cycle against an event-time model.
module tb_led_status_driver;
  localparam int PULSE = 4;
  localparam int BH    = 3;
  localparam int BC    = 2;
  localparam int HB    = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_nibble = '0;
  logic       ovf_set = 1'b0, ovf_clr = 1'b0, err_start = 1'b0;
  logic [7:0] led_input, leds_sel;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  led_status_driver #(
    .CNT_W(27), .PULSE_CYC(PULSE), .BLINK_HALF(BH), .BLINK_COUNT(BC), .HB_HALF(HB)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_nibble(key_nibble),
    .ovf_set(ovf_set), .ovf_clr(ovf_clr), .err_start(err_start),
    .led_input(led_input), .leds_sel(leds_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: n counts clock edges since reset release; each LED bit is derived
  // from the edge index of the most recent relevant event.
  int         n, nk, ne, m;
  bit         have_key, err_act, ovf_m, model_ok, b_now;
  logic [3:0] nib_m;
  logic [7:0] w_now, w1, w2, exp_led, exp_sel;
  bit         exp_busy;

  initial model_ok = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      n = 0; nk = 0; ne = 0; have_key = 0; err_act = 0; ovf_m = 0; nib_m = '0;
      w1 = '0; w2 = '0; exp_led = '0; exp_sel = '0; exp_busy = 0; model_ok = 1;
    end else begin
      n++;
      if (key_valid) begin nk = n; have_key = 1; nib_m = key_nibble; end
      if (ovf_set) ovf_m = 1; else if (ovf_clr) ovf_m = 0;
      if (err_start) begin ne = n; err_act = 1; end
      m = n - ne;
      b_now = err_act && (m < 2 * BH * BC);
      w_now = {((n / HB) % 2) == 1,
               b_now && ((m % (2 * BH)) < BH),
               ovf_m,
               have_key && ((n - nk) < PULSE),
               nib_m};
      if (n == 1) begin exp_led = 8'h00; exp_sel = 8'hFF; end
      else begin exp_led = w1; exp_sel = w1 ^ w2; end
      exp_busy = b_now;
      w2 = w1; w1 = w_now;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      vectors++;
      if (led_input !== exp_led || leds_sel !== exp_sel || busy !== exp_busy) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t: got led=%h sel=%h busy=%b, want led=%h sel=%h busy=%b",
                 $time, led_input, leds_sel, busy, exp_led, exp_sel, exp_busy);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic [7:0] l, input logic [7:0] s);
    vectors++;
    if (led_input !== l || leds_sel !== s) begin
      miscompares++;
      $display("FAIL %s: got led=%h sel=%h, want led=%h sel=%h", name, led_input, leds_sel, l, s);
    end
  endtask

  task automatic chk_busy(input string name, input logic b);
    vectors++;
    if (busy !== b) begin
      miscompares++;
      $display("FAIL %s: got busy=%b, want busy=%b", name, busy, b);
    end
  endtask

  initial begin
    step(3);
    chk_out("reset_out", 8'h00, 8'h00);
    chk_busy("reset_busy", 1'b0);
    reset = 1'b1;
    step(1);  chk_out("init_write", 8'h00, 8'hFF);
    step(1);  chk_out("post_init", 8'h00, 8'h00);
    step(9);  chk_out("hb_toggle", 8'h80, 8'h80);
    step(1);  chk_out("hb_hold", 8'h80, 8'h00);
    key_valid = 1'b1; key_nibble = 4'hA;
    step(1);  key_valid = 1'b0;
    chk_out("key_latency", 8'h80, 8'h00);
    step(1);  chk_out("key_write", 8'h9A, 8'h1A);
    step(3);  chk_out("key_held", 8'h9A, 8'h00);
    step(1);  chk_out("key_expire", 8'h8A, 8'h10);
    ovf_set = 1'b1; ovf_clr = 1'b1;
    step(1);  ovf_set = 1'b0; ovf_clr = 1'b0;
    step(1);  chk_out("ovf_set_wins", 8'hAA, 8'h20);
    step(1);  chk_out("hb_off", 8'h2A, 8'h80);
    ovf_clr = 1'b1;
    step(1);  ovf_clr = 1'b0;
    step(1);  chk_out("ovf_clr", 8'h0A, 8'h20);
    err_start = 1'b1;
    step(1);  err_start = 1'b0;
    chk_busy("blink_busy", 1'b1);
    chk_out("blink_latency", 8'h0A, 8'h00);
    step(1);  chk_out("blink_on", 8'h4A, 8'h40);
    step(3);  chk_out("blink_off", 8'h0A, 8'h40);
    step(7);  chk_busy("blink_last", 1'b1);
    step(1);  chk_busy("blink_done", 1'b0);
    err_start = 1'b1;
    step(1);  err_start = 1'b0;
    step(3);  err_start = 1'b1;
    step(1);  err_start = 1'b0;
    step(1);  chk_out("blink_restart", 8'h4A, 8'h40);
    step(10); chk_busy("restart_last", 1'b1);
    step(1);  chk_busy("restart_done", 1'b0);
    err_start = 1'b1;
    step(1);  err_start = 1'b0;
    step(2);  reset = 1'b0;
    step(1);  chk_busy("mid_reset_busy", 1'b0);
    chk_out("mid_reset_out", 8'h00, 8'h00);
    reset = 1'b1;
    step(1);  chk_out("reinit_write", 8'h00, 8'hFF);

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 499) != 0);
      key_valid  = ($urandom_range(0, 7) == 0);
      key_nibble = 4'($urandom_range(0, 15));
      ovf_set    = ($urandom_range(0, 15) == 0);
      ovf_clr    = ($urandom_range(0, 15) == 0);
      err_start  = ($urandom_range(0, 39) == 0);
      step(1);
    end
    reset = 1'b1; key_valid = 1'b0; ovf_set = 1'b0; ovf_clr = 1'b0; err_start = 1'b0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
